wb_cmd_master: RTL and testbench

- Single-outstanding Wishbone B4 classic-cycle initiator. It turns a valid/ready command stream (address, data, write enable, byte select) into one bus cycle and returns the result on a valid/ready response stream.
- Counterpart to the team's Wishbone slave peripherals such as the timer. Used by debug bridges, boot sequencers and test harnesses to drive register blocks.

---
 rtl/wb_cmd_master.sv | 136 +++++++++++++
 tb/tb_wb_cmd_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 classic-cycle initiator: command stream in, one bus cycle, response stream out.
// Optional bus timeout abort is built when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_adr,
  input  logic [31:0]           i_cmd_dat,
  input  logic [3:0]            i_cmd_sel,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_dat,
  output logic                  o_rsp_err,
  output logic                  o_rsp_timeout,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [3:0]            o_wb_sel,
  output logic [ADDR_WIDTH-1:0] o_wb_adr,
  output logic [31:0]           o_wb_dat,
  input  logic [31:0]           i_wb_dat,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state_q, state_d;
  logic   term;
  logic   expire;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be at least 1");
  end

  assign term        = (state_q == BUS) && (i_wb_ack || i_wb_err);
  assign o_cmd_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic          rsp_timeout_q;

  // Counter holds the number of unterminated BUS cycles already completed,
  // so the abort lands at the end of the TIMEOUT_CYCLES-th BUS cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt <= '0;
    end else if (state_q == BUS && !term) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign expire        = (state_q == BUS) && !term && (tmo_cnt == TMO_LAST);
  assign o_rsp_timeout = rsp_timeout_q;
`else
  assign expire        = 1'b0;
  assign o_rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_cmd_valid)     state_d = BUS;
      BUS:     if (term || expire)  state_d = RESP;
      RESP:    if (i_rsp_ready)     state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_sel    <= '0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_dat   <= '0;
      o_rsp_err   <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (i_cmd_valid) begin
          o_wb_cyc <= 1'b1;
          o_wb_stb <= 1'b1;
          o_wb_we  <= i_cmd_we;
          o_wb_sel <= i_cmd_sel;
          o_wb_adr <= i_cmd_adr;
          o_wb_dat <= i_cmd_dat;
        end
        BUS: if (term) begin
          o_wb_cyc    <= 1'b0;
          o_wb_stb    <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= i_wb_err;
          o_rsp_dat   <= (!o_wb_we && i_wb_ack && !i_wb_err) ? i_wb_dat : '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_q <= 1'b0;
`endif
        end else if (expire) begin
          o_wb_cyc    <= 1'b0;
          o_wb_stb    <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b1;
          o_rsp_dat   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_timeout_q <= 1'b1;
`endif
        end
        RESP: if (i_rsp_ready) o_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed vector table, random transactions against a
// transaction-level reference, plus hang/timeout and mid-cycle reset sequences.
module tb_wb_cmd_master;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [31:0]   cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_dat;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err, busy;
  logic [3:0]    wb_sel;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_o, wb_dat_i;

  wb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_dat(rsp_dat),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o), .i_wb_dat(wb_dat_i),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    int            lat;      // BUS cycle on which the slave terminates
    logic          ack;
    logic          err;
    logic [31:0]   rdat;
    int            rdy_wait; // cycles of response backpressure
    logic          stray;    // stray ACK pulse during RESP
    logic          exp_err;
    logic [31:0]   exp_dat;
    int            exp_cyc;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: a bus cycle lasts until the slave's terminating cycle; ERR dominates,
  // and only an ACKed read without ERR returns data.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err = v.err;
    r.exp_dat = (!v.we && v.ack && !v.err) ? v.rdat : 32'h0;
    r.exp_cyc = v.lat;
    return r;
  endfunction

  // Called and returning just after a negedge.
  task automatic run_txn(input vec_t v);
    int ncyc = 0;
    logic [31:0] held_dat;
    logic        held_err;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~v.we; cmd_adr = ~v.adr; cmd_dat = $urandom; cmd_sel = ~v.sel;
    for (int k = 0; k < 300; k++) begin
      if (!wb_cyc) break;
      ncyc++;
      chk("bus_stb", {31'b0, wb_stb}, 32'd1);
      chk("bus_we",  {31'b0, wb_we}, {31'b0, v.we});
      chk("bus_adr", {28'b0, wb_adr}, {28'b0, v.adr});
      chk("bus_sel", {28'b0, wb_sel}, {28'b0, v.sel});
      chk("bus_dat", wb_dat_o, v.dat);
      if (ncyc == v.lat) begin
        wb_ack = v.ack; wb_err = v.err; wb_dat_i = v.rdat;
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
      end
      @(posedge clk); @(negedge clk);
    end
    wb_ack = 1'b0; wb_err = 1'b0;
    chk("cyc_length", ncyc, v.exp_cyc);
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk("rsp_dat", rsp_dat, v.exp_dat);
    chk("rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk("cmd_ready_resp", {31'b0, cmd_ready}, 32'd0);
    chk("stb_resp", {31'b0, wb_stb}, 32'd0);
    held_dat = rsp_dat; held_err = rsp_err;
    for (int w = 0; w < v.rdy_wait; w++) begin
      if (v.stray && w == 0) begin wb_ack = 1'b1; wb_dat_i = ~v.exp_dat; end
      @(posedge clk); @(negedge clk);
      wb_ack = 1'b0;
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_dat", rsp_dat, v.exp_dat);
      chk("bp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_cyc", {31'b0, wb_cyc}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    chk("back_idle", {31'b0, cmd_ready}, 32'd1);
    chk("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;

    //        we    adr    dat            sel    lat ack   err   rdat           rdy stray exp_err exp_dat        cyc
    tbl[0] = '{1'b1, 4'h1, 32'h0000_1234, 4'hF, 2, 1'b1, 1'b0, 32'hAAAA_0000, 0, 1'b0, 1'b0, 32'h0,         2};
    tbl[1] = '{1'b0, 4'h2, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
    tbl[2] = '{1'b0, 4'h3, 32'h0,         4'hF, 1, 1'b1, 1'b1, 32'h5555_5555, 0, 1'b0, 1'b1, 32'h0,         1};
    tbl[3] = '{1'b0, 4'hF, 32'h1111_2222, 4'h3, 1, 1'b1, 1'b0, 32'h0BAD_F00D, 5, 1'b1, 1'b0, 32'h0BAD_F00D, 1};
    tbl[4] = '{1'b1, 4'h7, 32'hCAFE_0001, 4'h8, 4, 1'b0, 1'b1, 32'h7777_7777, 1, 1'b1, 1'b1, 32'h0,         4};
    tbl[5] = '{1'b0, 4'h0, 32'h0,         4'h1, 2, 1'b0, 1'b1, 32'h1234_5678, 2, 1'b0, 1'b1, 32'h0,         2};

    #12;
    chk("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("rst_stb", {31'b0, wb_stb}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_wb_adr", {28'b0, wb_adr}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_txn(tbl[i]);

    for (int n = 0; n < 40; n++) begin
      int kind;
      rv.we = 1'($urandom); rv.adr = AW'($urandom); rv.dat = $urandom; rv.sel = 4'($urandom);
      rv.lat = $urandom_range(1, 3);
      kind = $urandom_range(0, 2);
      rv.ack = (kind != 1); rv.err = (kind != 0);
      rv.rdat = $urandom; rv.rdy_wait = $urandom_range(0, 3); rv.stray = 1'($urandom);
      run_txn(model(rv));
    end

    // Slave that never terminates.
    begin
      int ncyc = 0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 4'h5; cmd_dat = 32'h0; cmd_sel = 4'hF;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (!wb_cyc) break;
        ncyc++;
        @(posedge clk); @(negedge clk);
      end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      chk("tmo_cyc_length", ncyc, 4);
      chk("tmo_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("tmo_rsp_err", {31'b0, rsp_err}, 32'd1);
      chk("tmo_rsp_timeout", {31'b0, rsp_timeout}, 32'd1);
      chk("tmo_rsp_dat", rsp_dat, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      chk("tmo_idle", {31'b0, cmd_ready}, 32'd1);
`else
      chk("hang_cyc_length", ncyc, 100);
      chk("hang_cyc", {31'b0, wb_cyc}, 32'd1);
      chk("hang_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
      chk("hang_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("hang_recover", {31'b0, cmd_ready}, 32'd1);
`endif
    end

    // Reset while in BUS: CYC/STB must drop before the next clock edge.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'h9; cmd_dat = 32'h0F0F_0F0F; cmd_sel = 4'hF;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_bus_cyc", {31'b0, wb_cyc}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("async_rst_stb", {31'b0, wb_stb}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
      chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_cyc", {31'b0, wb_cyc}, 32'd0);
    end

    run_txn(model('{1'b0, 4'hA, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'h600D_CAFE, 0, 1'b0, 1'b0, 32'h0, 0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
